// File: rtl/motor_ramp_ctrl.sv
// Multi-channel H-bridge PWM controller: shared period counter, per-channel RUN/STOP/DEAD reversal sequencing.
// Define MOTOR_RAMP_EN for STEP-limited duty ramping; otherwise duty jumps to its target on each ramp tick.
module motor_ramp_ctrl #(
    parameter int N_CH         = 2,
    parameter int DUTY_W       = 10,
    parameter int CLK_HZ       = 100_000_000,
    parameter int PWM_HZ       = 25_000,
    parameter int STEP         = 64,
    parameter int RAMP_PERIODS = 1,
    parameter int DEAD_PERIODS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_ch,
    input  logic              cmd_dir,
    input  logic [DUTY_W-1:0] cmd_duty,
    output logic [N_CH-1:0]   pwm,
    output logic [N_CH-1:0]   in_a,
    output logic [N_CH-1:0]   in_b,
    output logic [N_CH-1:0]   busy,
    output logic              cmd_err
);

    localparam int PERIOD = CLK_HZ / PWM_HZ;
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int PROD_W = CNT_W + DUTY_W;
    localparam int RAMP_W = $clog2(RAMP_PERIODS + 1);
    localparam int DEAD_W = $clog2(DEAD_PERIODS + 1);
    localparam int FULL   = 1 << DUTY_W;
`ifdef MOTOR_RAMP_EN
    localparam int STEP_EFF = STEP;
`else
    // A step of at least full scale makes every ramp tick land exactly on the target.
    localparam int STEP_EFF = (STEP > FULL) ? STEP : FULL;
`endif

    typedef enum logic [1:0] {IDLE, RUN, STOP, DEAD} state_t;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RAMP_W-1:0] rampCnt_q, rampCnt_d;
    state_t            state_q [N_CH];
    state_t            state_d [N_CH];
    logic [DUTY_W-1:0] curDuty_q [N_CH];
    logic [DUTY_W-1:0] curDuty_d [N_CH];
    logic [DUTY_W-1:0] tgtDuty_q [N_CH];
    logic [DUTY_W-1:0] tgtDuty_d [N_CH];
    logic [DEAD_W-1:0] deadCnt_q [N_CH];
    logic [DEAD_W-1:0] deadCnt_d [N_CH];
    logic [N_CH-1:0]   curDir_q, curDir_d, tgtDir_q, tgtDir_d;
    logic [N_CH-1:0]   inA_q, inA_d, inB_q, inB_d;
    logic              ready_q, err_q, err_d;
    logic              boundary, rampTick, accept;

    function automatic logic [DUTY_W-1:0] rampStep(input logic [DUTY_W-1:0] cur,
                                                   input logic [DUTY_W-1:0] eff);
        int c;
        int e;
        c = int'(cur);
        e = int'(eff);
        if (e > c + STEP_EFF) return DUTY_W'(c + STEP_EFF);
        if (e < c - STEP_EFF) return DUTY_W'(c - STEP_EFF);
        return eff;
    endfunction

    // Duty and direction only change on the wrap cycle so a running pulse is never cut short.
    always_comb begin
        boundary  = (cnt_q == CNT_W'(PERIOD - 1));
        rampTick  = boundary && (rampCnt_q == RAMP_W'(RAMP_PERIODS - 1));
        accept    = cmd_valid && ready_q;
        cnt_d     = boundary ? '0 : cnt_q + CNT_W'(1);
        rampCnt_d = rampTick ? '0 : (boundary ? rampCnt_q + RAMP_W'(1) : rampCnt_q);
        err_d     = accept && ({1'b0, cmd_ch} >= 4'(N_CH));
        curDir_d  = curDir_q;
        tgtDir_d  = tgtDir_q;
        inA_d     = '0;
        inB_d     = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i]   = state_q[i];
            curDuty_d[i] = curDuty_q[i];
            tgtDuty_d[i] = tgtDuty_q[i];
            deadCnt_d[i] = deadCnt_q[i];
            if (accept && (cmd_ch == 3'(i))) begin
                tgtDuty_d[i] = cmd_duty;
                tgtDir_d[i]  = cmd_dir;
            end
            if (boundary) begin
                case (state_q[i])
                    IDLE: begin
                        if (tgtDuty_q[i] != '0) begin
                            state_d[i]   = RUN;
                            curDir_d[i]  = tgtDir_q[i];
                            curDuty_d[i] = rampTick ? rampStep('0, tgtDuty_q[i]) : '0;
                        end
                    end
                    RUN: begin
                        if (tgtDir_q[i] != curDir_q[i]) begin
                            state_d[i]   = STOP;
                            curDuty_d[i] = rampTick ? rampStep(curDuty_q[i], '0) : curDuty_q[i];
                            if (curDuty_d[i] == '0) begin
                                state_d[i]   = DEAD;
                                deadCnt_d[i] = '0;
                            end
                        end else begin
                            curDuty_d[i] = rampTick ? rampStep(curDuty_q[i], tgtDuty_q[i]) : curDuty_q[i];
                            if ((tgtDuty_q[i] == '0) && (curDuty_d[i] == '0)) state_d[i] = IDLE;
                        end
                    end
                    STOP: begin
                        curDuty_d[i] = rampTick ? rampStep(curDuty_q[i], '0) : curDuty_q[i];
                        if (curDuty_d[i] == '0) begin
                            state_d[i]   = DEAD;
                            deadCnt_d[i] = '0;
                        end
                    end
                    DEAD: begin
                        if (deadCnt_q[i] == DEAD_W'(DEAD_PERIODS - 1)) begin
                            curDir_d[i] = tgtDir_q[i];
                            if (tgtDuty_q[i] == '0) begin
                                state_d[i] = IDLE;
                            end else begin
                                state_d[i]   = RUN;
                                curDuty_d[i] = rampTick ? rampStep('0, tgtDuty_q[i]) : '0;
                            end
                        end else begin
                            deadCnt_d[i] = deadCnt_q[i] + DEAD_W'(1);
                        end
                    end
                    default: state_d[i] = IDLE;
                endcase
            end
            // Bridge drive follows the next state so it switches on the same edge as the duty.
            inA_d[i] = ((state_d[i] == RUN) || (state_d[i] == STOP)) && !curDir_d[i];
            inB_d[i] = ((state_d[i] == RUN) || (state_d[i] == STOP)) &&  curDir_d[i];
        end
    end

    always_comb begin
        pwm  = '0;
        busy = '0;
        for (int i = 0; i < N_CH; i++) begin
            pwm[i]  = PROD_W'(cnt_q) < ((PROD_W'(PERIOD) * PROD_W'(curDuty_q[i])) >> DUTY_W);
            busy[i] = (curDuty_q[i] != tgtDuty_q[i])
                   || ((tgtDuty_q[i] != '0) && (curDir_q[i] != tgtDir_q[i]))
                   || (state_q[i] == STOP) || (state_q[i] == DEAD);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            rampCnt_q <= '0;
            curDir_q  <= '0;
            tgtDir_q  <= '0;
            inA_q     <= '0;
            inB_q     <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]   <= IDLE;
                curDuty_q[i] <= '0;
                tgtDuty_q[i] <= '0;
                deadCnt_q[i] <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            rampCnt_q <= rampCnt_d;
            curDir_q  <= curDir_d;
            tgtDir_q  <= tgtDir_d;
            inA_q     <= inA_d;
            inB_q     <= inB_d;
            ready_q   <= 1'b1;
            err_q     <= err_d;
            state_q   <= state_d;
            curDuty_q <= curDuty_d;
            tgtDuty_q <= tgtDuty_d;
            deadCnt_q <= deadCnt_d;
        end
    end

    assign cmd_ready = ready_q;
    assign cmd_err   = err_q;
    assign in_a      = inA_q;
    assign in_b      = inB_q;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: directed reversal/reset scenarios then random commands, checked every cycle
// against a period-level reference model; a 64-cycle PWM period keeps the run short.
module tb_motor_ramp_ctrl;

    localparam int N_CH   = 2;
    localparam int DUTY_W = 10;
    localparam int PERIOD = 64;
    localparam int STEP   = 64;
    localparam int DEAD   = 2;
    localparam int FULL   = 1 << DUTY_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_ch = '0;
    logic              cmd_dir = 1'b0;
    logic [DUTY_W-1:0] cmd_duty = '0;
    logic [N_CH-1:0]   pwm, in_a, in_b, busy;
    logic              cmd_err;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: per channel, applied-duty, targets, and reversal progress.
    int mDuty[N_CH], mTgt[N_CH], mDir[N_CH], mTdir[N_CH];
    int mActive[N_CH], mStopping[N_CH], mDeadLeft[N_CH];
    int highAcc[N_CH], lastHigh[N_CH];
    int benchCnt = 0;
    int readyExp = 0;
    int errExp = 0;

    motor_ramp_ctrl #(
        .N_CH(N_CH), .DUTY_W(DUTY_W), .CLK_HZ(PERIOD * 100), .PWM_HZ(100),
        .STEP(STEP), .RAMP_PERIODS(1), .DEAD_PERIODS(DEAD)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_dir(cmd_dir), .cmd_duty(cmd_duty),
        .pwm(pwm), .in_a(in_a), .in_b(in_b), .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int approach(int cur, int tgt);
`ifdef MOTOR_RAMP_EN
        int stepSize = STEP;
`else
        int stepSize = FULL;
`endif
        if (tgt > cur + stepSize) return cur + stepSize;
        if (tgt < cur - stepSize) return cur - stepSize;
        return tgt;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N_CH; i++) begin
            mDuty[i] = 0; mTgt[i] = 0; mDir[i] = 0; mTdir[i] = 0;
            mActive[i] = 0; mStopping[i] = 0; mDeadLeft[i] = 0;
        end
        benchCnt = 0;
        readyExp = 0;
        errExp = 0;
    endtask

    task automatic modelBoundary();
        for (int i = 0; i < N_CH; i++) begin
            if (mDeadLeft[i] > 0) begin
                mDeadLeft[i]--;
                if (mDeadLeft[i] == 0) begin
                    mDir[i] = mTdir[i];
                    mActive[i] = (mTgt[i] != 0);
                    mDuty[i] = approach(0, mTgt[i]);
                end
            end else if (mStopping[i] != 0 || (mActive[i] != 0 && mDir[i] != mTdir[i])) begin
                mStopping[i] = 1;
                mActive[i] = 0;
                mDuty[i] = approach(mDuty[i], 0);
                if (mDuty[i] == 0) begin
                    mStopping[i] = 0;
                    mDeadLeft[i] = DEAD;
                end
            end else if (mActive[i] != 0) begin
                mDuty[i] = approach(mDuty[i], mTgt[i]);
                if (mTgt[i] == 0 && mDuty[i] == 0) mActive[i] = 0;
            end else if (mTgt[i] != 0) begin
                mDir[i] = mTdir[i];
                mActive[i] = 1;
                mDuty[i] = approach(0, mTgt[i]);
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        logic [N_CH-1:0] ePwm, eA, eB, eBusy;
        @(posedge clk);
        if (rst) begin
            modelReset();
        end else begin
            if (benchCnt == PERIOD - 1) begin
                modelBoundary();
                benchCnt = 0;
            end else begin
                benchCnt++;
            end
            errExp = (cmd_valid && readyExp != 0 && int'(cmd_ch) >= N_CH) ? 1 : 0;
            if (cmd_valid && readyExp != 0 && int'(cmd_ch) < N_CH) begin
                mTgt[cmd_ch] = int'(cmd_duty);
                mTdir[cmd_ch] = int'(cmd_dir);
            end
            readyExp = 1;
        end
        @(negedge clk);
        for (int i = 0; i < N_CH; i++) begin
            ePwm[i]  = benchCnt < (PERIOD * mDuty[i]) / FULL;
            eA[i]    = (mActive[i] != 0 || mStopping[i] != 0) && mDir[i] == 0;
            eB[i]    = (mActive[i] != 0 || mStopping[i] != 0) && mDir[i] != 0;
            eBusy[i] = mDuty[i] != mTgt[i] || (mTgt[i] != 0 && mDir[i] != mTdir[i])
                    || mStopping[i] != 0 || mDeadLeft[i] != 0;
            if (benchCnt == 0) highAcc[i] = 0;
            highAcc[i] += int'(pwm[i]);
            if (benchCnt == PERIOD - 1) lastHigh[i] = highAcc[i];
        end
        checkOutput("pwm", 32'(pwm), 32'(ePwm));
        checkOutput("in_a", 32'(in_a), 32'(eA));
        checkOutput("in_b", 32'(in_b), 32'(eB));
        checkOutput("ab_excl", 32'(in_a & in_b), 32'd0);
        checkOutput("busy", 32'(busy), 32'(eBusy));
        checkOutput("cmd_err", 32'(cmd_err), 32'(errExp));
        checkOutput("cmd_ready", 32'(cmd_ready), 32'(readyExp));
    endtask

    task automatic runCycles(input int n);
        for (int k = 0; k < n; k++) stepCycle();
    endtask

    task automatic waitCount(input int c);
        while (benchCnt != c) stepCycle();
    endtask

    task automatic applyStimulus(input int ch, input int dir, input int duty);
        cmd_valid = 1'b1;
        cmd_ch    = 3'(ch);
        cmd_dir   = 1'(dir);
        cmd_duty  = DUTY_W'(duty);
        stepCycle();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int duty;
        int ch;
        rst = 1'b1;
        runCycles(2);
        checkOutput("rst_ready", 32'(cmd_ready), 32'd0);
        checkOutput("rst_pwm", 32'(pwm | in_a | in_b | busy), 32'd0);
        rst = 1'b0;
        stepCycle();
        checkOutput("ready_up", 32'(cmd_ready), 32'd1);

        // Forward start to half duty.
        waitCount(5);
        applyStimulus(0, 0, 512);
        runCycles(10 * PERIOD);
        waitCount(PERIOD - 1);
        checkOutput("high512", 32'(lastHigh[0]), 32'(PERIOD / 2));
        checkOutput("fwd_a", 32'(in_a[0]), 32'd1);
        checkOutput("fwd_b", 32'(in_b[0]), 32'd0);

        // Reversal: ramp down, dead time, ramp up the other way.
        applyStimulus(0, 1, 512);
        runCycles(20 * PERIOD);
        waitCount(PERIOD - 1);
        checkOutput("rev_high", 32'(lastHigh[0]), 32'(PERIOD / 2));
        checkOutput("rev_a", 32'(in_a[0]), 32'd0);
        checkOutput("rev_b", 32'(in_b[0]), 32'd1);

        // Out-of-range channel only pulses cmd_err.
        applyStimulus(5, 0, 300);
        checkOutput("err_pulse", 32'(cmd_err), 32'd1);
        stepCycle();
        checkOutput("err_drop", 32'(cmd_err), 32'd0);

        // Near-full and zero duty on channel 1.
        applyStimulus(1, 0, 1023);
        runCycles(18 * PERIOD);
        waitCount(PERIOD - 1);
        checkOutput("high1023", 32'(lastHigh[1]), 32'((PERIOD * 1023) / FULL));
        applyStimulus(1, 0, 0);
        runCycles(20 * PERIOD);
        waitCount(PERIOD - 1);
        checkOutput("high0", 32'(lastHigh[1]), 32'd0);
        checkOutput("idle_busy", 32'(busy[1]), 32'd0);

        // Reset in the middle of the dead time.
        applyStimulus(0, 0, 700);
        for (int k = 0; k < 40 * PERIOD && mDeadLeft[0] == 0; k++) stepCycle();
        runCycles(PERIOD / 2);
        checkOutput("dead_busy", 32'(busy[0]), 32'd1);
        checkOutput("dead_ab", 32'(in_a[0] | in_b[0]), 32'd0);
        rst = 1'b1;
        stepCycle();
        checkOutput("rst_dead_out", 32'(pwm | in_a | in_b | busy), 32'd0);
        checkOutput("rst_dead_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        stepCycle();
        checkOutput("rst_dead_ready1", 32'(cmd_ready), 32'd1);

        // Random commands, mostly to valid channels, with extreme duties mixed in.
        for (int n = 0; n < 40; n++) begin
            ch = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 7)) : int'($urandom_range(0, N_CH - 1));
            case ($urandom_range(0, 3))
                0:       duty = 0;
                1:       duty = FULL - 1;
                default: duty = int'($urandom_range(1, FULL - 1));
            endcase
            applyStimulus(ch, int'($urandom_range(0, 1)), duty);
            runCycles(int'($urandom_range(0, 12 * PERIOD)));
        end
        runCycles(30 * PERIOD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
